// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with a 2-bit saturating direction counter
//   per entry, sitting beside the fetch stage.
//
//   Ports
//     iCLOCK                  clock, rising edge
//     inRESET                 asynchronous reset, active low
//     iFLUSH                  start an invalidate sweep (single-cycle pulse)
//     oBUSY                   sweep in progress
//     iSEARCH_STB             search request
//     iSEARCH_INST_ADDR       fetched instruction address
//     oSEARCH_VALID           search result valid, one cycle after the request
//     oSEARCH_HIT             entry valid and tag matched
//     oSEARCH_PREDICT_BRANCH  predicted taken (counter msb), 0 on miss
//     oSEARCH_ADDR            predicted target, 0 on miss
//     iJUMP_STB               resolved-branch update strobe
//     iJUMP_VALID             1 = branch taken, 0 = not taken
//     iJUMP_ADDR              resolved target address
//     iJUMP_INST_ADDR         address of the resolved branch instruction
module branch_target_buffer #(
  parameter int unsigned P_INDEX_W  = 4,
  parameter logic [1:0]  P_INIT_CNT = 2'b10
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  output logic        oBUSY,
  input  logic        iSEARCH_STB,
  input  logic [31:0] iSEARCH_INST_ADDR,
  output logic        oSEARCH_VALID,
  output logic        oSEARCH_HIT,
  output logic        oSEARCH_PREDICT_BRANCH,
  output logic [31:0] oSEARCH_ADDR,
  input  logic        iJUMP_STB,
  input  logic        iJUMP_VALID,
  input  logic [31:0] iJUMP_ADDR,
  input  logic [31:0] iJUMP_INST_ADDR
);

  localparam int unsigned Entries = 1 << P_INDEX_W;
  localparam int unsigned TagW    = 30 - P_INDEX_W;
  localparam logic [P_INDEX_W-1:0] LastIdx = '1;

  typedef enum logic [0:0] {StIdle, StFlush} stateT;

  stateT                stateQ, stateD;
  logic [P_INDEX_W-1:0] flushIdxQ, flushIdxD;

  // Entry storage
  logic            validQ  [Entries];
  logic            validD  [Entries];
  logic [TagW-1:0] tagQ    [Entries];
  logic [TagW-1:0] tagD    [Entries];
  logic [31:0]     targetQ [Entries];
  logic [31:0]     targetD [Entries];
  logic [1:0]      cntQ    [Entries];
  logic [1:0]      cntD    [Entries];

  // Registered search result
  logic        searchValidQ, searchHitQ, searchPredQ;
  logic [31:0] searchAddrQ;
  logic        searchHitD, searchPredD;
  logic [31:0] searchAddrD;

  // Address split
  logic [P_INDEX_W-1:0] searchIdx, jumpIdx;
  logic [TagW-1:0]      searchTag, jumpTag;

  assign searchIdx = iSEARCH_INST_ADDR[P_INDEX_W+1:2];
  assign searchTag = iSEARCH_INST_ADDR[31:P_INDEX_W+2];
  assign jumpIdx   = iJUMP_INST_ADDR[P_INDEX_W+1:2];
  assign jumpTag   = iJUMP_INST_ADDR[31:P_INDEX_W+2];

  logic isIdle;
  logic updateEn;
  logic jumpHit;
  logic searchMatch;

  assign isIdle   = (stateQ == StIdle);
  // A flush request in the same cycle takes priority and drops the update.
  assign updateEn = isIdle && iJUMP_STB && !iFLUSH;
  assign jumpHit  = validQ[jumpIdx] && (tagQ[jumpIdx] == jumpTag);

  // Lookup reads the current (pre-update) contents, giving read-before-write on a
  // same-cycle search/update collision. Results are forced to miss while sweeping.
  assign searchMatch = isIdle && validQ[searchIdx] && (tagQ[searchIdx] == searchTag);

  always_comb begin
    searchHitD  = 1'b0;
    searchPredD = 1'b0;
    searchAddrD = 32'h0;
    if (iSEARCH_STB && searchMatch) begin
      searchHitD  = 1'b1;
      searchPredD = cntQ[searchIdx][1];
      searchAddrD = targetQ[searchIdx];
    end
  end

  // Sweep FSM
  always_comb begin
    stateD    = stateQ;
    flushIdxD = flushIdxQ;
    unique case (stateQ)
      StIdle: begin
        if (iFLUSH) begin
          stateD    = StFlush;
          flushIdxD = '0;
        end
      end
      StFlush: begin
        if (iFLUSH) begin
          flushIdxD = '0;
        end else begin
          // Index wraps to 0 on the same edge that returns to idle.
          flushIdxD = flushIdxQ + 1'b1;
          if (flushIdxQ == LastIdx) begin
            stateD = StIdle;
          end
        end
      end
      default: begin
        stateD    = StIdle;
        flushIdxD = '0;
      end
    endcase
  end

  // Entry next-state: either one sweep clear or one training update per cycle.
  always_comb begin
    validD  = validQ;
    tagD    = tagQ;
    targetD = targetQ;
    cntD    = cntQ;
    if (stateQ == StFlush) begin
      validD[flushIdxQ] = 1'b0;
    end else if (updateEn) begin
      if (jumpHit) begin
        if (iJUMP_VALID) begin
          cntD[jumpIdx]    = (cntQ[jumpIdx] == 2'b11) ? 2'b11 : cntQ[jumpIdx] + 2'd1;
          targetD[jumpIdx] = iJUMP_ADDR;
        end else begin
          cntD[jumpIdx] = (cntQ[jumpIdx] == 2'b00) ? 2'b00 : cntQ[jumpIdx] - 2'd1;
        end
      end else if (iJUMP_VALID) begin
        validD[jumpIdx]  = 1'b1;
        tagD[jumpIdx]    = jumpTag;
        targetD[jumpIdx] = iJUMP_ADDR;
        cntD[jumpIdx]    = P_INIT_CNT;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stateQ       <= StIdle;
      flushIdxQ    <= '0;
      searchValidQ <= 1'b0;
      searchHitQ   <= 1'b0;
      searchPredQ  <= 1'b0;
      searchAddrQ  <= 32'h0;
      for (int i = 0; i < int'(Entries); i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= 32'h0;
        cntQ[i]    <= 2'b00;
      end
    end else begin
      stateQ       <= stateD;
      flushIdxQ    <= flushIdxD;
      searchValidQ <= iSEARCH_STB;
      searchHitQ   <= searchHitD;
      searchPredQ  <= searchPredD;
      searchAddrQ  <= searchAddrD;
      for (int i = 0; i < int'(Entries); i++) begin
        validQ[i]  <= validD[i];
        tagQ[i]    <= tagD[i];
        targetQ[i] <= targetD[i];
        cntQ[i]    <= cntD[i];
      end
    end
  end

  assign oBUSY                  = (stateQ == StFlush);
  assign oSEARCH_VALID          = searchValidQ;
  assign oSEARCH_HIT            = searchHitQ;
  assign oSEARCH_PREDICT_BRANCH = searchPredQ;
  assign oSEARCH_ADDR           = searchAddrQ;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iFLUSH;
  logic        oBUSY;
  logic        iSEARCH_STB;
  logic [31:0] iSEARCH_INST_ADDR;
  logic        oSEARCH_VALID;
  logic        oSEARCH_HIT;
  logic        oSEARCH_PREDICT_BRANCH;
  logic [31:0] oSEARCH_ADDR;
  logic        iJUMP_STB;
  logic        iJUMP_VALID;
  logic [31:0] iJUMP_ADDR;
  logic [31:0] iJUMP_INST_ADDR;

  int tests = 0;
  int fails = 0;

  branch_target_buffer #(
    .P_INDEX_W (4),
    .P_INIT_CNT(2'b10)
  ) dut (
    .iCLOCK                (iCLOCK),
    .inRESET               (inRESET),
    .iFLUSH                (iFLUSH),
    .oBUSY                 (oBUSY),
    .iSEARCH_STB           (iSEARCH_STB),
    .iSEARCH_INST_ADDR     (iSEARCH_INST_ADDR),
    .oSEARCH_VALID         (oSEARCH_VALID),
    .oSEARCH_HIT           (oSEARCH_HIT),
    .oSEARCH_PREDICT_BRANCH(oSEARCH_PREDICT_BRANCH),
    .oSEARCH_ADDR          (oSEARCH_ADDR),
    .iJUMP_STB             (iJUMP_STB),
    .iJUMP_VALID           (iJUMP_VALID),
    .iJUMP_ADDR            (iJUMP_ADDR),
    .iJUMP_INST_ADDR       (iJUMP_INST_ADDR)
  );

  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        jStb;
    logic        jVal;
    logic [31:0] jInst;
    logic [31:0] jAddr;
    logic        sStb;
    logic [31:0] sAddr;
    logic        eV;
    logic        eH;
    logic        eP;
    logic [31:0] eA;
  } vecT;

  localparam int NumVec = 27;
  vecT vecs [NumVec];

  function automatic vecT mk(input logic jStb, input logic jVal, input logic [31:0] jInst,
                             input logic [31:0] jAddr, input logic sStb,
                             input logic [31:0] sAddr, input logic eV, input logic eH,
                             input logic eP, input logic [31:0] eA);
    vecT v;
    v.jStb = jStb; v.jVal = jVal; v.jInst = jInst; v.jAddr = jAddr;
    v.sStb = sStb; v.sAddr = sAddr;
    v.eV = eV; v.eH = eH; v.eP = eP; v.eA = eA;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clearInputs();
    iFLUSH            = 1'b0;
    iSEARCH_STB       = 1'b0;
    iSEARCH_INST_ADDR = 32'h0;
    iJUMP_STB         = 1'b0;
    iJUMP_VALID       = 1'b0;
    iJUMP_ADDR        = 32'h0;
    iJUMP_INST_ADDR   = 32'h0;
  endtask

  task automatic jump(input logic taken, input logic [31:0] inst, input logic [31:0] tgt);
    iJUMP_STB       = 1'b1;
    iJUMP_VALID     = taken;
    iJUMP_INST_ADDR = inst;
    iJUMP_ADDR      = tgt;
    cyc();
    clearInputs();
  endtask

  task automatic searchExpect(input string name, input logic [31:0] addr, input logic eH,
                              input logic eP, input logic [31:0] eA);
    iSEARCH_STB       = 1'b1;
    iSEARCH_INST_ADDR = addr;
    cyc();
    clearInputs();
    chk({name, " valid"}, {31'b0, oSEARCH_VALID}, 32'd1);
    chk({name, " hit"}, {31'b0, oSEARCH_HIT}, {31'b0, eH});
    chk({name, " pred"}, {31'b0, oSEARCH_PREDICT_BRANCH}, {31'b0, eP});
    chk({name, " addr"}, oSEARCH_ADDR, eA);
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      jump(1'b1, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(16 * i));
    end
  endtask

  initial begin
    int busyCount;
    int c;

    // Index 0 for P_INDEX_W=4: 0x100, 0x140, 0x200, 0x300; 0x104 is index 1.
    vecs[0]  = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 32'h100, 32'h800,  0, 32'h0,   0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 1, 1, 32'h800);
    vecs[3]  = mk(1, 0, 32'h100, 32'h0,    0, 32'h0,   0, 0, 0, 32'h0);     // cnt 1
    vecs[4]  = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 1, 0, 32'h800);
    vecs[5]  = mk(1, 0, 32'h100, 32'h0,    0, 32'h0,   0, 0, 0, 32'h0);     // cnt 0
    vecs[6]  = mk(1, 0, 32'h100, 32'h0,    0, 32'h0,   0, 0, 0, 32'h0);     // cnt 0 (sat)
    vecs[7]  = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 1, 0, 32'h800);
    vecs[8]  = mk(1, 1, 32'h100, 32'h800,  0, 32'h0,   0, 0, 0, 32'h0);     // cnt 1
    vecs[9]  = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 1, 0, 32'h800);
    vecs[10] = mk(1, 1, 32'h100, 32'h800,  0, 32'h0,   0, 0, 0, 32'h0);     // cnt 2
    vecs[11] = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 1, 1, 32'h800);
    vecs[12] = mk(1, 1, 32'h100, 32'h800,  0, 32'h0,   0, 0, 0, 32'h0);     // cnt 3
    vecs[13] = mk(1, 1, 32'h100, 32'h880,  0, 32'h0,   0, 0, 0, 32'h0);     // cnt 3 (sat)
    vecs[14] = mk(1, 0, 32'h100, 32'h0,    0, 32'h0,   0, 0, 0, 32'h0);     // cnt 2
    vecs[15] = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 1, 1, 32'h880);
    vecs[16] = mk(1, 1, 32'h140, 32'h900,  0, 32'h0,   0, 0, 0, 32'h0);     // replace
    vecs[17] = mk(0, 0, 32'h0,   32'h0,    1, 32'h100, 1, 0, 0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,   32'h0,    1, 32'h140, 1, 1, 1, 32'h900);
    vecs[19] = mk(1, 1, 32'h200, 32'hA00,  1, 32'h200, 1, 0, 0, 32'h0);     // read-before-write
    vecs[20] = mk(0, 0, 32'h0,   32'h0,    1, 32'h200, 1, 1, 1, 32'hA00);
    vecs[21] = mk(1, 0, 32'h300, 32'hB00,  0, 32'h0,   0, 0, 0, 32'h0);     // miss NT: no change
    vecs[22] = mk(0, 0, 32'h0,   32'h0,    1, 32'h200, 1, 1, 1, 32'hA00);
    vecs[23] = mk(0, 0, 32'h0,   32'h0,    1, 32'h300, 1, 0, 0, 32'h0);
    vecs[24] = mk(0, 0, 32'h0,   32'h0,    1, 32'h203, 1, 1, 1, 32'hA00);   // addr[1:0] ignored
    vecs[25] = mk(1, 1, 32'h104, 32'h1234, 0, 32'h0,   0, 0, 0, 32'h0);
    vecs[26] = mk(0, 0, 32'h0,   32'h0,    1, 32'h104, 1, 1, 1, 32'h1234);

    clearInputs();
    inRESET = 1'b0;
    cyc();
    cyc();
    chk("reset busy", {31'b0, oBUSY}, 32'd0);
    chk("reset valid", {31'b0, oSEARCH_VALID}, 32'd0);
    chk("reset hit", {31'b0, oSEARCH_HIT}, 32'd0);
    chk("reset addr", oSEARCH_ADDR, 32'h0);
    inRESET = 1'b1;
    cyc();

    for (int i = 0; i < NumVec; i++) begin
      iJUMP_STB         = vecs[i].jStb;
      iJUMP_VALID       = vecs[i].jVal;
      iJUMP_INST_ADDR   = vecs[i].jInst;
      iJUMP_ADDR        = vecs[i].jAddr;
      iSEARCH_STB       = vecs[i].sStb;
      iSEARCH_INST_ADDR = vecs[i].sAddr;
      cyc();
      clearInputs();
      chk($sformatf("vec%0d valid", i), {31'b0, oSEARCH_VALID}, {31'b0, vecs[i].eV});
      chk($sformatf("vec%0d hit", i), {31'b0, oSEARCH_HIT}, {31'b0, vecs[i].eH});
      chk($sformatf("vec%0d pred", i), {31'b0, oSEARCH_PREDICT_BRANCH}, {31'b0, vecs[i].eP});
      chk($sformatf("vec%0d addr", i), oSEARCH_ADDR, vecs[i].eA);
    end

    // Full flush sweep: length, forced miss during sweep, dropped updates.
    fill16();
    searchExpect("fill idx15", 32'h103C, 1'b1, 1'b1, 32'h20F0);
    chk("idle busy", {31'b0, oBUSY}, 32'd0);
    iFLUSH = 1'b1;
    cyc();
    clearInputs();
    busyCount = 0;
    c = 0;
    while (oBUSY && c < 40) begin
      busyCount++;
      if (c == 0) begin
        iSEARCH_STB       = 1'b1;
        iSEARCH_INST_ADDR = 32'h103C;
      end
      if (c == 9) begin
        iJUMP_STB       = 1'b1;
        iJUMP_VALID     = 1'b1;
        iJUMP_INST_ADDR = 32'h5008;
        iJUMP_ADDR      = 32'h7777;
      end
      cyc();
      clearInputs();
      if (c == 0) begin
        chk("sweep search valid", {31'b0, oSEARCH_VALID}, 32'd1);
        chk("sweep search hit", {31'b0, oSEARCH_HIT}, 32'd0);
        chk("sweep search addr", oSEARCH_ADDR, 32'h0);
      end
      c++;
    end
    chk("sweep busy cycles", busyCount, 32'd16);
    for (int i = 0; i < 16; i++) begin
      searchExpect($sformatf("post-flush idx%0d", i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0,
                   32'h0);
    end
    searchExpect("dropped update", 32'h5008, 1'b0, 1'b0, 32'h0);

    // Flush requested together with an update: the update is dropped.
    iFLUSH          = 1'b1;
    iJUMP_STB       = 1'b1;
    iJUMP_VALID     = 1'b1;
    iJUMP_INST_ADDR = 32'h6004;
    iJUMP_ADDR      = 32'h4444;
    cyc();
    clearInputs();
    c = 0;
    while (oBUSY && c < 40) begin
      cyc();
      c++;
    end
    searchExpect("flush beats update", 32'h6004, 1'b0, 1'b0, 32'h0);

    // Restart: a second pulse at sweep cycle 3 gives 4 + 16 busy cycles.
    iFLUSH = 1'b1;
    cyc();
    clearInputs();
    busyCount = 0;
    c = 0;
    while (oBUSY && c < 60) begin
      busyCount++;
      if (c == 3) iFLUSH = 1'b1;
      cyc();
      clearInputs();
      c++;
    end
    chk("restart busy cycles", busyCount, 32'd20);

    // Reset in the middle of a sweep.
    fill16();
    searchExpect("refill idx10", 32'h1028, 1'b1, 1'b1, 32'h20A0);
    iFLUSH = 1'b1;
    cyc();
    clearInputs();
    for (int k = 0; k < 5; k++) cyc();
    chk("mid-sweep busy", {31'b0, oBUSY}, 32'd1);
    inRESET = 1'b0;
    #1;
    chk("reset mid-sweep busy", {31'b0, oBUSY}, 32'd0);
    cyc();
    chk("reset held busy", {31'b0, oBUSY}, 32'd0);
    inRESET = 1'b1;
    cyc();
    chk("after reset busy", {31'b0, oBUSY}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      searchExpect($sformatf("post-reset idx%0d", i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0,
                   32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
